// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-Lite to multi-slave APB3 bridge.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    StIdle,
    StWwait,
    StSetup,
    StAccess,
    StErr1,
    StErr2
  } bridge_state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  function automatic int unsigned sel_width(int unsigned num_slv);
    return (num_slv > 1) ? $clog2(num_slv) : 1;
  endfunction

  // A zero timeout still needs a 1-bit counter so the datapath stays well formed.
  function automatic int unsigned cnt_width(int unsigned timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_slv_decode.sv
// Address decoder: picks the APB slave index from a fixed haddr bit field.
module apb_slv_decode
  import ahb_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_LSB = 12,
  localparam int unsigned SEL_W  = sel_width(NUM_SLV)
) (
  input  logic [ADDR_W-1:0] haddr,
  output logic              hit,
  output logic [SEL_W-1:0]  idx
);

  logic unused_haddr;
  assign unused_haddr = ^haddr;

  assign idx = haddr[SEL_LSB +: SEL_W];
  // Widened compare so a power-of-two slave count does not fold to a constant.
  assign hit = ({1'b0, idx} < (SEL_W + 1)'(NUM_SLV));

endmodule

// File: rtl/ahb_apb_bridge_mslv.sv
// AHB-Lite slave to APB3 master bridge with per-slave decode, PREADY wait states,
// PSLVERR / decode-miss / timeout mapped onto a two-cycle AHB ERROR response.
module ahb_apb_bridge_mslv
  import ahb_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_LSB = 12,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                      clk,
  input  logic                      hresetn,
  input  logic                      hsel,
  input  logic [ADDR_W-1:0]         haddr,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic                      hreadyin,
  input  logic [DATA_W-1:0]         hwdata,
  output logic [DATA_W-1:0]         hrdata,
  output logic                      hreadyout,
  output logic                      hresp,
  output logic [ADDR_W-1:0]         paddr,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int unsigned SEL_W = sel_width(NUM_SLV);
  localparam int unsigned CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  bridge_state_t       state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                hreadyout_q, hreadyout_d;
  logic                hresp_q, hresp_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;

  logic                dec_hit;
  logic [SEL_W-1:0]    dec_idx;
  logic                capture;
  htrans_t             trans;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;

  apb_slv_decode #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .SEL_LSB (SEL_LSB)
  ) u_decode (
    .haddr (haddr),
    .hit   (dec_hit),
    .idx   (dec_idx)
  );

  function automatic logic [NUM_SLV-1:0] onehot(logic [SEL_W-1:0] sel);
    logic [NUM_SLV-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (sel == SEL_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign trans   = htrans_t'(htrans);
  assign capture = hsel && hreadyin && hreadyout_q &&
                   (trans == HtransNonseq || trans == HtransSeq) &&
                   (state_q == StIdle || state_q == StErr2);

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (idx_q == SEL_W'(i)) begin
        sel_ready = pready[i];
        sel_err   = pslverr[i];
        sel_rdata = prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    hrdata_d    = hrdata_q;

    unique case (state_q)
      StIdle, StErr2: begin
        if (capture) begin
          idx_d       = dec_idx;
          hreadyout_d = 1'b0;
          if (dec_hit) begin
            hresp_d  = HRESP_OKAY;
            paddr_d  = haddr;
            pwrite_d = hwrite;
            if (hwrite) begin
              state_d = StWwait;
            end else begin
              state_d = StSetup;
              psel_d  = onehot(dec_idx);
              cnt_d   = '0;
            end
          end else begin
            state_d = StErr1;
            hresp_d = HRESP_ERROR;
          end
        end else begin
          state_d     = StIdle;
          hreadyout_d = 1'b1;
          hresp_d     = HRESP_OKAY;
        end
      end
      StWwait: begin
        // Write data is only valid in the data phase, one cycle after capture.
        pwdata_d = hwdata;
        psel_d   = onehot(idx_q);
        cnt_d    = '0;
        state_d  = StSetup;
      end
      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
      end
      StAccess: begin
        if (sel_ready) begin
          psel_d    = '0;
          penable_d = 1'b0;
          if (sel_err) begin
            state_d = StErr1;
            hresp_d = HRESP_ERROR;
          end else begin
            state_d     = StIdle;
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_OKAY;
            if (!pwrite_q) hrdata_d = sel_rdata;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = StErr1;
          hresp_d   = HRESP_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StErr1: begin
        state_d     = StErr2;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_ERROR;
      end
      default: begin
        state_d     = StIdle;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        psel_d      = '0;
        penable_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      hrdata_q    <= hrdata_d;
    end
  end

  assign hrdata    = hrdata_q;
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_mslv.sv
// Randomized bench for ahb_apb_bridge_mslv: a transfer-level model predicts every cycle's outputs.
module tb_ahb_apb_bridge_mslv;

  localparam int NS = 5;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;
  localparam logic [NS-1:0] NONE = '0;

  logic              clk = 1'b0;
  logic              hresetn = 1'b0;
  logic              hsel = 1'b0;
  logic [AW-1:0]     haddr = '0;
  logic [1:0]        htrans = 2'b00;
  logic              hwrite = 1'b0;
  logic              hreadyin = 1'b1;
  logic [DW-1:0]     hwdata = '0;
  logic [DW-1:0]     hrdata;
  logic              hreadyout;
  logic              hresp;
  logic [AW-1:0]     paddr;
  logic [NS-1:0]     psel;
  logic              penable;
  logic              pwrite;
  logic [DW-1:0]     pwdata;
  logic [NS*DW-1:0]  prdata = '0;
  logic [NS-1:0]     pready = '0;
  logic [NS-1:0]     pslverr = '0;

  ahb_apb_bridge_mslv #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .NUM_SLV (NS),
    .SEL_LSB (12),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .hresetn   (hresetn),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hreadyin  (hreadyin),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rdy;
    logic          resp;
    logic [NS-1:0] psel;
    logic          pen;
    logic          chk_bus;
    logic [31:0]   paddr;
    logic          pwrite;
    logic [31:0]   pwdata;
    logic [31:0]   hrdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          chk_on = 1'b0;
  int          stall_cnt = 0;
  int          acc_cnt = 0;

  // Architectural state as the bus sees it between transfers.
  logic [31:0] m_paddr = '0;
  logic        m_pwrite = 1'b0;
  logic [31:0] m_pwdata = '0;
  logic [31:0] m_hrdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=0x%08h want=0x%08h", nm, cyc, act, expv);
    end
  endtask

  task automatic push(input logic rdy, input logic resp, input logic [NS-1:0] ps,
                      input logic pen, input logic cb);
    exp_t r;
    r.rdy = rdy; r.resp = resp; r.psel = ps; r.pen = pen; r.chk_bus = cb;
    r.paddr = m_paddr; r.pwrite = m_pwrite; r.pwdata = m_pwdata; r.hrdata = m_hrdata;
    exp_q.push_back(r);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (hreadyout === 1'b0) stall_cnt++;
    if (penable === 1'b1 && psel != NONE) acc_cnt++;
    if (chk_on) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL model_underrun cycle=%0d got=empty want=record", cyc);
      end else begin
        cur_e = exp_q.pop_front();
        chk("hreadyout", 32'(hreadyout), 32'(cur_e.rdy));
        chk("hresp", 32'(hresp), 32'(cur_e.resp));
        chk("psel", 32'(psel), 32'(cur_e.psel));
        chk("penable", 32'(penable), 32'(cur_e.pen));
        chk("hrdata", hrdata, cur_e.hrdata);
        if (cur_e.chk_bus) begin
          chk("paddr", paddr, cur_e.paddr);
          chk("pwrite", 32'(pwrite), 32'(cur_e.pwrite));
          chk("pwdata", pwdata, cur_e.pwdata);
        end
      end
    end
  end

  // Address-phase inputs that must never start a transfer when hreadyout is high.
  task automatic ahb_noise(input bit any);
    haddr    = $urandom;
    hwrite   = 1'($urandom);
    htrans   = 2'($urandom);
    hsel     = 1'($urandom);
    hreadyin = 1'($urandom);
    if (!any) begin
      case ($urandom_range(0, 2))
        0:       hsel = 1'b0;
        1:       htrans[1] = 1'b0;
        default: begin hsel = 1'b1; htrans = 2'b10; hreadyin = 1'b0; end
      endcase
    end
  endtask

  task automatic apb_drive(input int sel, input logic rdy, input logic err,
                           input logic [31:0] rd);
    for (int i = 0; i < NS; i++) begin
      prdata[i*DW +: DW] = $urandom;
      pready[i]  = 1'($urandom);
      pslverr[i] = 1'($urandom);
    end
    if (sel >= 0 && sel < NS) begin
      pready[sel]  = rdy;
      pslverr[sel] = err;
      prdata[sel*DW +: DW] = rd;
    end
  endtask

  task automatic idle_cycle();
    ahb_noise(1'b0);
    apb_drive(-1, 1'b0, 1'b0, 32'h0);
    push(1'b1, 1'b0, NONE, 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  // Called in a cycle where the bridge is ready; returns in the last (ready) cycle of the transfer.
  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input int w, input logic err, input logic [31:0] rd);
    int idx, s, acc, len;
    bit hit, fail;
    logic [NS-1:0] oh;
    logic r;
    idx = int'(addr[14:12]);
    hit = idx < NS;
    oh = '0;
    if (hit) oh[idx] = 1'b1;
    s = wr ? 3 : 2;
    if (!hit) begin
      push(1'b0, 1'b1, NONE, 1'b0, 1'b1);
      push(1'b1, 1'b1, NONE, 1'b0, 1'b1);
      len = 2;
    end else begin
      m_paddr  = addr;
      m_pwrite = wr;
      if (wr) begin
        push(1'b0, 1'b0, NONE, 1'b0, 1'b0);
        m_pwdata = wd;
      end
      push(1'b0, 1'b0, oh, 1'b0, 1'b1);
      fail = err || (w >= TO);
      acc  = (w >= TO) ? TO : w + 1;
      repeat (acc) push(1'b0, 1'b0, oh, 1'b1, 1'b1);
      if (fail) begin
        push(1'b0, 1'b1, NONE, 1'b0, 1'b1);
        push(1'b1, 1'b1, NONE, 1'b0, 1'b1);
      end else begin
        if (!wr) m_hrdata = rd;
        push(1'b1, 1'b0, NONE, 1'b0, 1'b1);
      end
      len = (s - 1) + acc + (fail ? 2 : 1);
    end
    hsel = 1'b1; hreadyin = 1'b1; haddr = addr; hwrite = wr;
    htrans = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
    hwdata = $urandom;
    apb_drive(-1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    for (int k = 1; k <= len; k++) begin
      if (k == 1) hwdata = wd;
      if (k < len) ahb_noise(1'b1);
      r = (k >= s) ? ((k - s) >= w) : 1'($urandom);
      apb_drive(hit ? idx : -1, r, err, rd);
      if (k < len) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, a0;
    logic [31:0] addr;
    logic wr, err;
    int w;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hreadyout", 32'(hreadyout), 32'h1);
    chk("rst_hresp", 32'(hresp), 32'h0);
    chk("rst_psel", 32'(psel), 32'h0);
    chk("rst_penable", 32'(penable), 32'h0);
    chk("rst_pwrite", 32'(pwrite), 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_hrdata", hrdata, 32'h0);
    hresetn = 1'b1;
    push(1'b1, 1'b0, NONE, 1'b0, 1'b1);
    chk_on = 1'b1;
    idle_cycle();

    s0 = stall_cnt;
    do_xfer(32'h0000_2004, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_0001);
    chk("t1_stall", stall_cnt - s0, 32'd2);
    chk("t1_hrdata", hrdata, 32'hCAFE_0001);
    chk("t1_hresp", 32'(hresp), 32'h0);
    idle_cycle();

    s0 = stall_cnt;
    do_xfer(32'h0000_1010, 1'b1, 32'hA5A5_A5A5, 0, 1'b0, 32'h0BAD_0BAD);
    chk("t2_stall", stall_cnt - s0, 32'd3);
    chk("t2_pwdata", pwdata, 32'hA5A5_A5A5);
    chk("t2_hrdata_kept", hrdata, 32'hCAFE_0001);
    idle_cycle();

    s0 = stall_cnt; a0 = acc_cnt;
    do_xfer(32'h0000_0040, 1'b0, 32'h0, 5, 1'b0, 32'h1234_5678);
    chk("t3_stall", stall_cnt - s0, 32'd7);
    chk("t3_access", acc_cnt - a0, 32'd6);
    idle_cycle();

    s0 = stall_cnt;
    do_xfer(32'h0000_3000, 1'b1, 32'h5555_0003, 0, 1'b1, 32'h0);
    chk("t4_stall", stall_cnt - s0, 32'd4);
    chk("t4_err2_hresp", 32'(hresp), 32'h1);
    chk("t4_err2_ready", 32'(hreadyout), 32'h1);
    idle_cycle();

    s0 = stall_cnt; a0 = acc_cnt;
    do_xfer(32'h0000_5000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    chk("t5_stall", stall_cnt - s0, 32'd1);
    chk("t5_access", acc_cnt - a0, 32'd0);
    chk("t5_hresp", 32'(hresp), 32'h1);
    idle_cycle();

    s0 = stall_cnt; a0 = acc_cnt;
    do_xfer(32'h0000_4008, 1'b0, 32'h0, 50, 1'b0, 32'h0);
    chk("t6_access", acc_cnt - a0, 32'd8);
    chk("t6_stall", stall_cnt - s0, 32'd10);
    chk("t6_hresp", 32'(hresp), 32'h1);
    idle_cycle();

    s0 = stall_cnt;
    do_xfer(32'h0000_1100, 1'b0, 32'h0, 0, 1'b0, 32'h1111_0001);
    do_xfer(32'h0000_2200, 1'b0, 32'h0, 0, 1'b0, 32'h2222_0002);
    chk("b2b_stall", stall_cnt - s0, 32'd4);
    chk("b2b_hrdata", hrdata, 32'h2222_0002);

    for (int t = 0; t < 150; t++) begin
      addr = $urandom;
      addr[1:0] = 2'b00;
      wr  = 1'($urandom);
      w   = ($urandom_range(0, 4) == 0) ? $urandom_range(3, 11) : $urandom_range(0, 2);
      err = ($urandom_range(0, 5) == 0);
      do_xfer(addr, wr, $urandom, w, err, $urandom);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();

    // Asynchronous reset in the middle of an access phase.
    chk_on = 1'b0;
    exp_q.delete();
    hsel = 1'b1; hreadyin = 1'b1; htrans = 2'b10; haddr = 32'h0000_1008; hwrite = 1'b0;
    apb_drive(1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    ahb_noise(1'b1);
    apb_drive(1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    apb_drive(1, 1'b0, 1'b0, 32'h0);
    chk("ar_penable_before", 32'(penable), 32'h1);
    chk("ar_psel_before", 32'(psel), 32'h2);
    #2 hresetn = 1'b0;
    hsel = 1'b0;
    #1;
    chk("ar_hreadyout", 32'(hreadyout), 32'h1);
    chk("ar_hresp", 32'(hresp), 32'h0);
    chk("ar_psel", 32'(psel), 32'h0);
    chk("ar_penable", 32'(penable), 32'h0);
    chk("ar_pwrite", 32'(pwrite), 32'h0);
    chk("ar_paddr", paddr, 32'h0);
    chk("ar_pwdata", pwdata, 32'h0);
    chk("ar_hrdata", hrdata, 32'h0);
    @(posedge clk); #1;
    hresetn = 1'b1;
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_hrdata = '0;
    push(1'b1, 1'b0, NONE, 1'b0, 1'b1);
    chk_on = 1'b1;
    for (int t = 0; t < 20; t++) begin
      addr = $urandom;
      addr[1:0] = 2'b00;
      do_xfer(addr, 1'($urandom), $urandom, $urandom_range(0, 3), 1'b0, $urandom);
      idle_cycle();
    end
    idle_cycle();
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
